// File: rtl/int_to_fp8_encoder.sv
// Signed integer to fp8 (1/4/3, bias 7) converter: one normalise shift per cycle,
// then round-to-nearest-even, with saturation to {sign,7'h7F} on exponent overflow.
//
// state | meaning
// IDLE  | waiting to accept in_data
// NORM  | shifting mag left until its MSB is set
// ROUND | RNE on the normalised mantissa, produce out_fp/out_ovf
// DONE  | out_fp presented, waiting for out_ready
module int_to_fp8_encoder #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_fp,
    output logic            out_ovf
);

    localparam int EW = IN_W + 6;
    localparam logic [EW-1:0] EXP_INIT = EW'(IN_W + 6);
    localparam logic [EW-1:0] EXP_MAX  = EW'(14);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic            sign;
    logic [IN_W-1:0] mag;
    logic [EW-1:0]   exp_r;

    logic [IN_W-1:0] in_abs;
    logic [2:0]      m;
    logic            g;
    logic            s;
    logic            rnd;
    logic [3:0]      m_sum;
    logic [EW-1:0]   exp_fin;

    assign in_ready  = (state == IDLE) && ena;
    assign out_valid = (state == DONE) && ena;

    // Magnitude is unsigned IN_W bits, so the most negative input maps to 2^(IN_W-1).
    always_comb begin
        in_abs  = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
        m       = mag[IN_W-2 -: 3];
        g       = mag[IN_W-5];
        s       = |mag[IN_W-6:0];
        rnd     = g & (s | m[0]);
        m_sum   = {1'b0, m} + {3'b000, rnd};
        exp_fin = exp_r + {{(EW-1){1'b0}}, m_sum[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            exp_r   <= '0;
            out_fp  <= 8'h00;
            out_ovf <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= in_data[IN_W-1];
                        mag   <= in_abs;
                        exp_r <= EXP_INIT;
                        if (in_abs == '0) begin
                            out_fp  <= 8'h00;
                            out_ovf <= 1'b0;
                            state   <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (!mag[IN_W-1]) begin
                        mag   <= mag << 1;
                        exp_r <= exp_r - EW'(1);
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (exp_fin > EXP_MAX) begin
                        out_fp  <= {sign, 7'h7F};
                        out_ovf <= 1'b1;
                    end else begin
                        out_fp  <= {sign, exp_fin[3:0], m_sum[2:0]};
                        out_ovf <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp8_encoder.sv
// Bench for int_to_fp8_encoder: 8-bit and 16-bit instances, directed cases plus
// random values checked against an arithmetic fp8 reference model.
module tb_int_to_fp8_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        out_ready;

    logic        in_valid8, in_ready8, out_valid8, out_ovf8;
    logic [7:0]  in_data8, out_fp8;
    logic        in_valid16, in_ready16, out_valid16, out_ovf16;
    logic [15:0] in_data16;
    logic [7:0]  out_fp16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_to_fp8_encoder #(.IN_W(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_fp(out_fp8), .out_ovf(out_ovf8)
    );

    int_to_fp8_encoder #(.IN_W(16)) dut16 (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_fp(out_fp16), .out_ovf(out_ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: value = 1.m * 2^e with m rounded to 3 bits, nearest-even.
    function automatic void model(input int val, output logic [7:0] fp, output logic ovf);
        int a, e, scaled, m, rem, half;
        bit s;
        s = (val < 0);
        a = s ? -val : val;
        fp = 8'h00;
        ovf = 1'b0;
        if (a != 0) begin
            e = 0;
            while ((a >> (e + 1)) != 0) e++;
            scaled = (a - (1 << e)) * 8;
            m = scaled / (1 << e);
            rem = scaled % (1 << e);
            half = (1 << e) / 2;
            if (rem > half || (rem == half && rem != 0 && (m % 2) == 1)) m++;
            if (m == 8) begin
                m = 0;
                e++;
            end
            if (e + 7 > 14) begin
                fp = {s, 7'h7F};
                ovf = 1'b1;
            end else begin
                fp = {s, 4'(e + 7), 3'(m)};
            end
        end
    endfunction

    function automatic int exp_lat(input int w, input int val);
        int a, e;
        a = (val < 0) ? -val : val;
        if (a == 0) return 1;
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        return 2 + (w - 1 - e);
    endfunction

    task automatic convert(input bit sel, input int val, input int stall_at, input int stall_len,
                           output logic [7:0] fp, output logic ovf, output int lat);
        bit done;
        @(negedge clk);
        if (sel) begin
            in_data16 = 16'(val);
            in_valid16 = 1'b1;
        end else begin
            in_data8 = 8'(val);
            in_valid8 = 1'b1;
        end
        #1;
        chk("in_ready_at_accept", sel ? in_ready16 : in_ready8, 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid16 = 1'b0;
        in_data8 = 8'($urandom);
        in_data16 = 16'($urandom);
        lat = 0;
        done = 1'b0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (stall_len > 0) ena = !(lat >= stall_at && lat < stall_at + stall_len);
            #1;
            if (!ena) begin
                chk("stall_in_ready", sel ? in_ready16 : in_ready8, 0);
                chk("stall_out_valid", sel ? out_valid16 : out_valid8, 0);
            end
            done = sel ? out_valid16 : out_valid8;
        end
        chk("out_valid_timeout", done, 1);
        fp = sel ? out_fp16 : out_fp8;
        ovf = sel ? out_ovf16 : out_ovf8;
    endtask

    task automatic drain(input bit sel);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        chk("idle_after_handshake_ready", sel ? in_ready16 : in_ready8, 1);
        chk("idle_after_handshake_valid", sel ? out_valid16 : out_valid8, 0);
    endtask

    task automatic run_case(input bit sel, input int val, input logic [7:0] want_fp, input logic want_ovf);
        logic [7:0] fp;
        logic ovf;
        int lat;
        convert(sel, val, 0, 0, fp, ovf, lat);
        chk($sformatf("fp_w%0d_%0d", sel ? 16 : 8, val), fp, want_fp);
        chk($sformatf("ovf_w%0d_%0d", sel ? 16 : 8, val), ovf, want_ovf);
        chk($sformatf("lat_w%0d_%0d", sel ? 16 : 8, val), lat, exp_lat(sel ? 16 : 8, val));
        drain(sel);
    endtask

    initial begin
        logic [7:0]  fp, mfp, hold_fp;
        logic        ovf, movf;
        logic [7:0]  r8;
        logic [15:0] r16;
        int          lat, v;

        rst = 1'b1;
        ena = 1'b1;
        out_ready = 1'b0;
        in_valid8 = 1'b0;
        in_valid16 = 1'b0;
        in_data8 = 8'h00;
        in_data16 = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_out_fp8", out_fp8, 8'h00);
        chk("rst_out_ovf8", out_ovf8, 0);
        chk("rst_in_ready8", in_ready8, 1);
        chk("rst_out_fp16", out_fp16, 8'h00);

        run_case(0, 5, 8'h4A, 0);
        run_case(0, -3, 8'hC4, 0);
        run_case(0, 25, 8'h5C, 0);
        run_case(0, 27, 8'h5E, 0);
        run_case(0, 127, 8'h70, 0);
        run_case(0, -128, 8'hF0, 0);
        run_case(0, 0, 8'h00, 0);
        run_case(0, 1, 8'h38, 0);

        // Backpressure: result must hold while out_ready is low.
        convert(0, 5, 0, 0, fp, ovf, lat);
        hold_fp = fp;
        chk("bp_fp", fp, 8'h4A);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_fp_stable", out_fp8, hold_fp);
            chk("bp_in_ready_low", in_ready8, 0);
            chk("bp_out_valid_high", out_valid8, 1);
        end
        drain(0);
        run_case(0, -3, 8'hC4, 0);

        // Enable stall mid-NORM for 3 cycles.
        convert(0, 1, 2, 3, fp, ovf, lat);
        chk("stall_fp", fp, 8'h38);
        chk("stall_lat", lat, 9 + 3);
        drain(0);

        run_case(1, 240, 8'h77, 0);
        run_case(1, 256, 8'h7F, 1);
        run_case(1, 248, 8'h7F, 1);
        run_case(1, -300, 8'hFF, 1);
        run_case(1, -32768, 8'hFF, 1);

        // Reset mid-NORM discards the conversion and clears outputs.
        @(negedge clk);
        in_data8 = 8'd1;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid8, 0);
        chk("midrst_out_fp", out_fp8, 8'h00);
        chk("midrst_in_ready", in_ready8, 1);
        chk("midrst_ovf16", out_ovf16, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_result", out_valid8, 0);

        for (int i = 0; i < 30; i++) begin
            r8 = 8'($urandom);
            v = $signed(r8);
            model(v, mfp, movf);
            convert(0, v, 0, 0, fp, ovf, lat);
            chk($sformatf("rnd8_fp_%0d", v), fp, mfp);
            chk($sformatf("rnd8_ovf_%0d", v), ovf, movf);
            chk($sformatf("rnd8_lat_%0d", v), lat, exp_lat(8, v));
            drain(0);
        end

        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) begin
                r16 = 16'($urandom);
                v = $signed(r16);
            end else begin
                v = int'($urandom_range(0, 700)) - 350;
            end
            model(v, mfp, movf);
            convert(1, v, 0, 0, fp, ovf, lat);
            chk($sformatf("rnd16_fp_%0d", v), fp, mfp);
            chk($sformatf("rnd16_ovf_%0d", v), ovf, movf);
            chk($sformatf("rnd16_lat_%0d", v), lat, exp_lat(16, v));
            drain(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_to_fp8_encoder.md
Name: int_to_fp8_encoder

Overview:
- Sequential converter from a signed two's-complement integer to the 8-bit float format consumed by the fp8 adder.
- Float format: sign[7], exponent[6:3], mantissa[2:0]; implicit leading 1; bias 7; no denormals. Code 0x00 is zero. Exponent 15 is reserved: {sign,7'h7F} means overflow/infinity.
- Sits upstream of the adder and produces its operands. Normalises one bit per cycle, then applies round-to-nearest-even.
- Valid/ready handshakes on both sides.

Parameters:
IN_W, 8, input integer width; legal range 8..16.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
ena  input  1  design enable; low freezes all state.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept in_data.
in_data  input  IN_W  signed integer to convert.
out_valid  output  1  out_fp is valid.
out_ready  input  1  downstream accepts out_fp.
out_fp  output  8  encoded float.
out_ovf  output  1  result saturated to {sign,7'h7F}.

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-conversion):
  - state goes to IDLE; out_fp=0x00, out_ovf=0, out_valid=0; all internal registers cleared.
  - an in-flight conversion is discarded.
- ena=0:
  - all registers hold their values.
  - in_ready and out_valid are forced to 0, so no handshake can complete.
  - conversion resumes when ena returns to 1.
- in_ready = (state==IDLE) & ena. Accept occurs when in_valid & in_ready at a clock edge.
- States:
  - IDLE:
    - On accept, latch sign = in_data[IN_W-1] and mag = |in_data| as an IN_W-bit unsigned value (so -2^(IN_W-1) becomes 2^(IN_W-1)).
    - Set exp = 7 + IN_W - 1 (IN_W+6 bits wide, no wrap).
    - If mag==0: out_fp<=0x00, out_ovf<=0, go to DONE (the sign of zero is dropped).
    - Otherwise go to NORM.
  - NORM, per cycle:
    - If mag[IN_W-1]==0: mag<=mag<<1, exp<=exp-1, stay in NORM.
    - Else go to ROUND.
  - ROUND (single cycle):
    - m = mag[IN_W-2:IN_W-4]; guard g = mag[IN_W-5]; sticky s = OR of mag[IN_W-6:0] (s=0 when IN_W=8? no: IN_W=8 gives s = OR of mag[2:0]).
    - Round up when g & (s | m[0]). On round-up, if m==3'b111 then m=0 and exp+1; otherwise m+1.
    - If the final exp>14: out_fp<={sign,7'h7F}, out_ovf<=1.
    - Else out_fp<={sign,exp[3:0],m}, out_ovf<=0.
    - Go to DONE.
  - DONE:
    - out_valid=1 (when ena=1). out_fp and out_ovf are stable while waiting.
    - On out_valid & out_ready, go to IDLE.
    - out_fp and out_ovf hold their value until the next ROUND or zero-accept.
- Latency from accept edge to first cycle with out_valid=1:
  - zero input: 1 cycle.
  - nonzero input: 2 + lz cycles, where lz = leading zeros of mag in IN_W bits.
  - This assumes ena stays high throughout.
- Throughput:
  - One conversion in flight at a time; no new accept until the DONE handshake.
  - The earliest new accept is the cycle after the output handshake.
- With IN_W=8 the exponent never exceeds 14, so overflow cannot occur.
- For IN_W>8, overflow occurs for |x| >= 248, where rounding carries into exponent 15.
- in_data is ignored outside accept cycles.
- A simultaneous rst and accept: rst wins.

Test Plan:
- IN_W=8, in_data=5 -> out_fp=0x4A, out_ovf=0, out_valid 7 cycles after accept. in_data=-3 -> 0xC4.
- Rounding, IN_W=8:
  - 25 -> 0x5C (tie, keeps even).
  - 27 -> 0x5E (tie, rounds up).
  - 127 -> 0x70 (mantissa carry into exponent 14).
- Extremes, IN_W=8:
  - -128 -> 0xF0, latency 2.
  - 0 -> 0x00, latency 1.
  - 1 -> 0x38, latency 9.
- Overflow, IN_W=16:
  - 240 -> 0x77, out_ovf=0.
  - 256 -> 0x7F, out_ovf=1.
  - -300 -> 0xFF, out_ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_fp stable, in_ready=0 throughout.
  - Raise out_ready -> IDLE the next cycle; a new accept is possible that cycle.
- Reset and enable:
  - Assert rst during NORM for in_data=1 -> next cycle IDLE, out_valid=0, out_fp=0x00.
  - Drop ena for 3 cycles mid-NORM -> latency grows by exactly 3 and the result is unchanged.
